spi_dac_rx: RTL and testbench

Receive end of the note-generation SPI link: deserializes the `sync`/`mosi`/`sclk` stream produced by the SPI master into parallel sample words for loopback checking and for a downstream DAC model. All three SPI lines are sampled in the system clock domain. Each word is offered on a ready/valid port. The block counts good frames and flags framing errors and overflows.

---
 rtl/spi_dac_rx_if.sv | 11 +
 rtl/spi_dac_rx.sv | 165 ++++++++++++++++
 tb/tb_spi_dac_rx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_dac_rx_if.sv
// Ready/valid word stream from the SPI receiver to its consumer.
interface spi_dac_rx_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/spi_dac_rx.sv
// SPI receive deserializer: synchronizes sclk/sync/mosi into clk, shifts frames
// on falling sclk, and offers each word on a ready/valid port with error pulses.
module spi_dac_rx #(
    parameter int WORD_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sclk,
    input  logic                sync,
    input  logic                mosi,
    spi_dac_rx_if.master        out_if,
    output logic                busy,
    output logic                frame_err,
    output logic                overflow,
    output logic [15:0]         frame_cnt
);
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0][2:0] pipe_q, pipe_d;
    logic              sclk_prev_q, sclk_prev_d;
    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              sclk_s, sync_s, mosi_s;
    logic              sample_edge;
    logic              word_done;
    logic [WORD_W-1:0] shreg_next;

    // All three lines share one pipeline so they stay aligned to each other.
    always_comb begin
        pipe_d[0] = {sclk, sync, mosi};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign sclk_s      = pipe_q[SYNC_STAGES-1][2];
    assign sync_s      = pipe_q[SYNC_STAGES-1][1];
    assign mosi_s      = pipe_q[SYNC_STAGES-1][0];
    assign sclk_prev_d = sclk_s;
    assign sample_edge = sclk_prev_q & ~sclk_s;
    assign shreg_next  = {shreg_q[WORD_W-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        if (sample_edge) begin
            wdog_d = '0;
        end else if (wdog_q == WD_MAX) begin
            wdog_d = wdog_q;
        end else begin
            wdog_d = wdog_q + WD_W'(1);
        end

        if (!en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shreg_d   = '0;
            wdog_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_edge && sync_s) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                    end
                end
                SHIFT: begin
                    if (sample_edge) begin
                        if (sync_s) begin
                            // A sync on the start edge's heels is just a restart, not an error.
                            frame_err_d = (bit_cnt_q != '0);
                            bit_cnt_d   = '0;
                            shreg_d     = '0;
                        end else begin
                            shreg_d   = shreg_next;
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            if (bit_cnt_q == LAST_BIT) begin
                                word_done = 1'b1;
                                state_d   = IDLE;
                            end
                        end
                    end else if (wdog_q == WD_MAX) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A new word may load on the same edge the pending one is accepted.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = 1'b0;
        if (word_done) begin
            if (!out_valid_q || out_if.out_ready) begin
                out_data_d  = shreg_next;
                out_valid_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q      <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            wdog_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            pipe_q      <= pipe_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            wdog_q      <= wdog_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign busy             = (state_q == SHIFT);
    assign frame_err        = frame_err_q;
    assign overflow         = overflow_q;
    assign frame_cnt        = frame_cnt_q;
endmodule

// File: tb/tb_spi_dac_rx.sv
// Self-checking bench for spi_dac_rx: directed scenarios plus randomized frames,
// compared every cycle against a frame-level behavioural model.
module tb_spi_dac_rx;
    localparam int WORD_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 1024;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        sclk_r = 1'b0;
    logic        sync_r = 1'b0;
    logic        mosi_r = 1'b0;
    logic        busy, frame_err, overflow;
    logic [15:0] frame_cnt;

    spi_dac_rx_if #(.WORD_W(WORD_W)) out_if ();

    spi_dac_rx #(
        .WORD_W(WORD_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .sclk(sclk_r), .sync(sync_r), .mosi(mosi_r),
        .out_if(out_if),
        .busy(busy), .frame_err(frame_err), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: raw-sample history gives the synchronized view; the rest
    // follows the frame rules directly.
    bit                h_sclk[$], h_sync[$], h_mosi[$];
    bit                m_in_frame, m_valid, m_ferr, m_ovf, m_done;
    int                m_nbits, m_idle, m_cnt;
    logic [WORD_W-1:0] m_word, m_data;

    always @(posedge clk or negedge rst_n) begin
        bit s_edge, s_sync, s_mosi;
        if (!rst_n) begin
            h_sclk.delete(); h_sync.delete(); h_mosi.delete();
            for (int i = 0; i <= SYNC_STAGES; i++) begin
                h_sclk.push_back(1'b0); h_sync.push_back(1'b0); h_mosi.push_back(1'b0);
            end
            m_in_frame = 0; m_valid = 0; m_ferr = 0; m_ovf = 0;
            m_nbits = 0; m_idle = 0; m_cnt = 0; m_word = '0; m_data = '0;
        end else begin
            s_edge = h_sclk[0] && !h_sclk[1];
            s_sync = h_sync[1];
            s_mosi = h_mosi[1];
            m_done = 0; m_ferr = 0; m_ovf = 0;
            if (!en) begin
                m_in_frame = 0; m_nbits = 0; m_word = '0; m_idle = 0;
            end else if (s_edge) begin
                m_idle = 0;
                if (s_sync) begin
                    if (m_in_frame && m_nbits > 0) m_ferr = 1;
                    m_in_frame = 1; m_nbits = 0; m_word = '0;
                end else if (m_in_frame) begin
                    m_word = (m_word << 1) | WORD_W'(s_mosi);
                    m_nbits++;
                    if (m_nbits == WORD_W) begin
                        m_done = 1; m_in_frame = 0;
                    end
                end
            end else begin
                if (m_in_frame && m_idle == TIMEOUT_CYC) begin
                    m_ferr = 1; m_in_frame = 0;
                end
                if (m_idle < TIMEOUT_CYC) m_idle++;
            end
            if (m_done) begin
                if (!m_valid || out_if.out_ready) begin
                    m_data = m_word; m_valid = 1; m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_valid && out_if.out_ready) begin
                m_valid = 0;
            end
            h_sclk.push_back(sclk_r); h_sclk.delete(0);
            h_sync.push_back(sync_r); h_sync.delete(0);
            h_mosi.push_back(mosi_r); h_mosi.delete(0);
        end
    end

    // True when the model will complete a word on the coming clk edge.
    function automatic bit done_next();
        return en && m_in_frame && (m_nbits == WORD_W - 1) &&
               h_sclk[0] && !h_sclk[1] && !h_sync[1];
    endfunction

    int checks = 0;
    int errors = 0;
    int tick_no = 0;
    int ferr_seen = 0, ovf_seen = 0, valid_seen = 0, ferr_tick = 0;
    bit rand_ready = 0, auto_ack = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clk cycle: compare against the model at the falling edge, then drive ready.
    task automatic tick();
        logic [35:0] act, exp;
        @(negedge clk);
        tick_no++;
        if (rst_n) begin
            act = {out_if.out_valid, busy, frame_err, overflow, frame_cnt, out_if.out_data};
            exp = {m_valid, m_in_frame, m_ferr, m_ovf, m_cnt[15:0], m_data};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("[TB] FAIL cycle %0d: dut %h model %h", tick_no, act, exp);
            end
            if (frame_err === 1'b1) begin
                ferr_seen++; ferr_tick = tick_no;
            end
            if (overflow === 1'b1) ovf_seen++;
            if (out_if.out_valid === 1'b1) valid_seen++;
        end
        if (auto_ack) out_if.out_ready = done_next();
        else if (rand_ready) out_if.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic spi_bit(input bit s, input bit m, input int hi, input int lo);
        sync_r = s; mosi_r = m; sclk_r = 1'b1;
        repeat (hi) tick();
        sclk_r = 1'b0;
        repeat (lo) tick();
    endtask

    // Optional sync edge, then the top nbits of w, MSB first.
    task automatic applyStimulus(input logic [15:0] w, input int nbits, input bit with_sync,
                                 input int hi, input int lo);
        if (with_sync) spi_bit(1'b1, 1'b0, hi, lo);
        for (int i = 0; i < nbits; i++) spi_bit(1'b0, w[WORD_W-1-i], hi, lo);
        sync_r = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int f0, o0, v0, fall_tick, kind, hi, lo;
        logic [15:0] w;
        out_if.out_ready = 1'b0;

        repeat (2) tick();
        checkOutput("reset_data",  32'(out_if.out_data), 32'h0);
        checkOutput("reset_valid", 32'(out_if.out_valid), 32'h0);
        checkOutput("reset_cnt",   32'(frame_cnt), 32'h0);
        checkOutput("reset_busy",  32'(busy), 32'h0);
        rst_n = 1'b1; en = 1'b1; out_if.out_ready = 1'b1;
        tick();

        $display("[TB] single frame");
        v0 = valid_seen; f0 = ferr_seen; o0 = ovf_seen;
        applyStimulus(16'hA5C3, 16, 1, 1, 3);
        repeat (8) tick();
        checkOutput("single_data", 32'(out_if.out_data), 32'hA5C3);
        checkOutput("single_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("single_valid_cycles", 32'(valid_seen - v0), 32'd1);
        checkOutput("single_errs", 32'(ferr_seen - f0 + ovf_seen - o0), 32'd0);
        checkOutput("single_model_data", 32'(m_data), 32'hA5C3);

        $display("[TB] back-pressure");
        do_reset();
        out_if.out_ready = 1'b0; o0 = ovf_seen;
        applyStimulus(16'h1234, 16, 1, 1, 3);
        applyStimulus(16'hBEEF, 16, 1, 1, 3);
        repeat (8) tick();
        checkOutput("bp_data", 32'(out_if.out_data), 32'h1234);
        checkOutput("bp_ovf", 32'(ovf_seen - o0), 32'd1);
        checkOutput("bp_cnt", 32'(frame_cnt), 32'd1);
        out_if.out_ready = 1'b1;
        tick();
        checkOutput("bp_drain_valid", 32'(out_if.out_valid), 32'h0);
        out_if.out_ready = 1'b0;

        $display("[TB] accept on completion");
        do_reset();
        o0 = ovf_seen;
        applyStimulus(16'h1111, 16, 1, 1, 3);
        repeat (6) tick();
        auto_ack = 1;
        applyStimulus(16'h2222, 16, 1, 1, 3);
        repeat (6) tick();
        auto_ack = 0; out_if.out_ready = 1'b0;
        tick();
        checkOutput("ack_data", 32'(out_if.out_data), 32'h2222);
        checkOutput("ack_valid", 32'(out_if.out_valid), 32'h1);
        checkOutput("ack_cnt", 32'(frame_cnt), 32'd2);
        checkOutput("ack_ovf", 32'(ovf_seen - o0), 32'd0);

        $display("[TB] resync");
        do_reset();
        out_if.out_ready = 1'b1; f0 = ferr_seen;
        applyStimulus(16'hFFFF, 7, 1, 1, 3);
        applyStimulus(16'h0F0F, 16, 1, 1, 3);
        repeat (8) tick();
        checkOutput("resync_ferr", 32'(ferr_seen - f0), 32'd1);
        checkOutput("resync_data", 32'(out_if.out_data), 32'h0F0F);
        checkOutput("resync_cnt", 32'(frame_cnt), 32'd1);

        $display("[TB] timeout");
        do_reset();
        f0 = ferr_seen;
        applyStimulus(16'hF800, 5, 1, 1, 3);
        fall_tick = tick_no - 3;
        repeat (1100) tick();
        checkOutput("timeout_ferr", 32'(ferr_seen - f0), 32'd1);
        checkOutput("timeout_when", 32'(ferr_tick - fall_tick), 32'(SYNC_STAGES + 2 + TIMEOUT_CYC));
        checkOutput("timeout_busy", 32'(busy), 32'h0);
        applyStimulus(16'h8001, 16, 1, 1, 3);
        repeat (8) tick();
        checkOutput("timeout_next_data", 32'(out_if.out_data), 32'h8001);
        checkOutput("timeout_next_cnt", 32'(frame_cnt), 32'd1);

        $display("[TB] async reset mid-frame");
        do_reset();
        out_if.out_ready = 1'b0;
        applyStimulus(16'h5555, 16, 1, 1, 3);
        applyStimulus(16'hFFFF, 9, 1, 1, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_outs",
                    32'({out_if.out_valid, busy, frame_err, overflow, frame_cnt}), 32'h0);
        checkOutput("arst_data", 32'(out_if.out_data), 32'h0);
        tick();
        rst_n = 1'b1; out_if.out_ready = 1'b1; f0 = ferr_seen;
        tick();
        applyStimulus(16'h7E7E, 16, 1, 1, 3);
        repeat (8) tick();
        checkOutput("arst_next_data", 32'(out_if.out_data), 32'h7E7E);
        checkOutput("arst_next_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("arst_no_ferr", 32'(ferr_seen - f0), 32'd0);

        $display("[TB] randomized frames");
        rand_ready = 1;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 4);
            w = 16'($urandom);
            if (kind == 0) begin
                applyStimulus(16'($urandom), $urandom_range(1, 15), 1, hi, lo);
            end else if (kind == 1) begin
                applyStimulus(16'($urandom), $urandom_range(0, 15), 1, hi, lo);
                en = 1'b0;
                repeat ($urandom_range(1, 6)) tick();
                en = 1'b1;
            end else if (kind == 2) begin
                applyStimulus(16'h0, 0, 1, hi, lo);
            end
            applyStimulus(w, 16, 1, hi, lo);
            repeat ($urandom_range(0, 8)) tick();
        end
        rand_ready = 0;
        out_if.out_ready = 1'b1;
        repeat (10) tick();
        checkOutput("random_final_cnt", 32'(frame_cnt), 32'(m_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
